// File: rtl/exe_pkg.sv
// Shared types and constants for the SCC execute stage.
package exe_pkg;

  // ALU operation codes; codes 10..15 are reserved.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_SHR = 4'd6,
    ALU_ASR = 4'd7,
    ALU_MOV = 4'd8,
    ALU_MUL = 4'd9
  } alu_op_t;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Execute stage control states.
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/exe_stage_alu_core.sv
// Combinational ALU for all single-cycle operations of the execute stage.
module alu_core
  import exe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       diff_s;
  logic [SHAMT_W-1:0]   shamt_s;
  logic                 carry_s;
  logic                 ovf_s;

  assign sum_s   = {1'b0, value1} + {1'b0, op2};
  // Subtraction as value1 + ~op2 + 1 so the carry out means "no borrow".
  assign diff_s  = {1'b0, value1} + {1'b0, ~op2} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt_s = op2[SHAMT_W-1:0];

  // Select the result and the carry/overflow contributions for the opcode.
  always_comb begin
    result  = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result  = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = (value1[WIDTH-1] == op2[WIDTH-1]) &&
                  (sum_s[WIDTH-1] != value1[WIDTH-1]);
      end
      ALU_SUB: begin
        result  = diff_s[WIDTH-1:0];
        carry_s = diff_s[WIDTH];
        ovf_s   = (value1[WIDTH-1] != op2[WIDTH-1]) &&
                  (diff_s[WIDTH-1] != value1[WIDTH-1]);
      end
      ALU_AND: result = value1 & op2;
      ALU_OR:  result = value1 | op2;
      ALU_XOR: result = value1 ^ op2;
      ALU_SHL: result = value1 << shamt_s;
      ALU_SHR: result = value1 >> shamt_s;
      ALU_ASR: result = WIDTH'($signed(value1) >>> shamt_s);
      ALU_MOV: result = op2;
      // MUL is produced by the iterative unit; reserved codes yield zero.
      default: result = {WIDTH{1'b0}};
    endcase
  end

  // Assemble the {N,Z,C,V} flag vector from the selected result.
  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == {WIDTH{1'b0}});
    flags[FLAG_C] = carry_s;
    flags[FLAG_V] = ovf_s;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand select, single-cycle ALU, iterative multiply and
// registered result/flags with valid/ready handshakes on both sides.
module exe_stage
  import exe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  input  logic [WIDTH-1:0] immediate,
  input  logic             ir_op,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_r;
  logic [WIDTH-1:0]   op2_s;
  logic [WIDTH-1:0]   alu_result_s;
  logic [3:0]         alu_flags_s;
  logic               accept_s;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   acc_next_s;
  logic [CNT_W-1:0]   count_r;

  // Multiply results only ever set N and Z.
  function automatic logic [3:0] mul_flags(input logic [WIDTH-1:0] r);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == {WIDTH{1'b0}});
    return f;
  endfunction

  assign op2_s      = ir_op ? value2 : immediate;
  assign in_ready   = (state_r == IDLE) && (!out_valid || out_ready);
  assign accept_s   = in_valid && in_ready;
  assign acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  alu_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .value1 (value1),
    .op2    (op2_s),
    .alu_op (alu_op),
    .result (alu_result_s),
    .flags  (alu_flags_s)
  );

  // Control FSM, shift-add multiplier and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      result    <= {WIDTH{1'b0}};
      flags     <= 4'b0000;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      count_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (alu_op == ALU_MUL) begin
              mcand_r   <= value1;
              mplier_r  <= op2_s;
              acc_r     <= {WIDTH{1'b0}};
              count_r   <= CNT_W'(WIDTH);
              busy      <= 1'b1;
              out_valid <= 1'b0;
              state_r   <= MUL;
            end else begin
              result    <= alu_result_s;
              flags     <= alu_flags_s;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end else begin
            out_valid <= out_valid;
          end
        end
        MUL: begin
          if (count_r != {CNT_W{1'b0}}) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r - CNT_W'(1);
            if (out_ready) begin
              out_valid <= 1'b0;
            end else begin
              out_valid <= out_valid;
            end
          end else begin
            // All partial products summed: publish and hold until consumed.
            result    <= acc_r;
            flags     <= mul_flags(acc_r);
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage (WIDTH=32).
module tb_exe_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value1;
  logic [31:0] value2;
  logic [31:0] immediate;
  logic        ir_op;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        busy;

  int checks;
  int failures;

  exe_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value1    (value1),
    .value2    (value2),
    .immediate (immediate),
    .ir_op     (ir_op),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] imm,
                         input logic iro);
    alu_op    = op;
    value1    = v1;
    value2    = v2;
    immediate = imm;
    ir_op     = iro;
    in_valid  = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int bad;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    value1    = 32'h0;
    value2    = 32'h0;
    immediate = 32'h0;
    ir_op     = 1'b0;
    alu_op    = 4'd0;

    // Reset state
    step();
    step();
    check("rst_result", result, 32'h0);
    check("rst_flags", {28'h0, flags}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // ADD with immediate wrapping to zero
    present(4'd0, 32'd5, 32'h0, 32'hFFFF_FFFB, 1'b0);
    step();
    check("add_valid", {31'h0, out_valid}, 32'h1);
    check("add_result", result, 32'h0);
    check("add_flags", {28'h0, flags}, {28'h0, 4'b0110});

    // Back-to-back stream, one op per edge
    present(4'd1, 32'h8000_0000, 32'h1, 32'h0, 1'b1);
    step();
    check("sub_result", result, 32'h7FFF_FFFF);
    check("sub_flags", {28'h0, flags}, {28'h0, 4'b0011});
    present(4'd2, 32'h0000_F0F0, 32'h0, 32'h0000_FF00, 1'b0);
    step();
    check("and_result", result, 32'h0000_F000);
    check("and_flags", {28'h0, flags}, 32'h0);
    present(4'd3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0, 1'b1);
    step();
    check("or_result", result, 32'h0000_FFFF);
    present(4'd4, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 1'b1);
    step();
    check("xor_result", result, 32'h0);
    check("xor_flags", {28'h0, flags}, {28'h0, 4'b0100});
    present(4'd5, 32'h1, 32'h0, 32'd31, 1'b0);
    step();
    check("shl_result", result, 32'h8000_0000);
    check("shl_flags", {28'h0, flags}, {28'h0, 4'b1000});
    present(4'd6, 32'h8000_0000, 32'h3F, 32'h0, 1'b1);
    step();
    check("shr_result", result, 32'h1);
    present(4'd7, 32'h8000_0000, 32'h24, 32'h0, 1'b1);
    step();
    check("asr_result", result, 32'hF800_0000);
    check("asr_flags", {28'h0, flags}, {28'h0, 4'b1000});
    present(4'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b1);
    step();
    check("addovf_result", result, 32'h8000_0000);
    check("addovf_flags", {28'h0, flags}, {28'h0, 4'b1001});
    present(4'd12, 32'd5, 32'd9, 32'd3, 1'b1);
    step();
    check("rsvd_result", result, 32'h0);
    check("rsvd_flags", {28'h0, flags}, {28'h0, 4'b0100});
    check("stream_valid", {31'h0, out_valid}, 32'h1);
    in_valid = 1'b0;
    step();
    check("idle_valid_clr", {31'h0, out_valid}, 32'h0);

    // MUL with concurrent ignored in_valid
    present(4'd9, 32'h0001_0003, 32'h0, 32'd5, 1'b0);
    step();
    check("mul_busy", {31'h0, busy}, 32'h1);
    check("mul_in_ready", {31'h0, in_ready}, 32'h0);
    present(4'd8, 32'h0, 32'h0, 32'h0000_00AA, 1'b0);
    n   = 0;
    bad = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
      if (!out_valid && (!busy || in_ready)) bad++;
    end
    in_valid = 1'b0;
    check("mul_latency", n, 32'd33);
    check("mul_hold_busy", bad, 32'd0);
    check("mul_result", result, 32'h0005_000F);
    check("mul_flags", {28'h0, flags}, 32'h0);
    check("mul_busy_done", {31'h0, busy}, 32'h0);
    step();
    check("mul_ignored_in", result, 32'h0005_000F);

    // Backpressure
    out_ready = 1'b0;
    present(4'd0, 32'd1, 32'd1, 32'h0, 1'b1);
    step();
    check("bp_add_result", result, 32'd2);
    present(4'd8, 32'h0, 32'h0, 32'd7, 1'b0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (in_ready) bad++;
      step();
      if (result != 32'd2 || !out_valid) bad++;
    end
    check("bp_hold", bad, 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    check("bp_mov_result", result, 32'd7);
    check("bp_mov_valid", {31'h0, out_valid}, 32'h1);
    step();
    check("bp_valid_clr", {31'h0, out_valid}, 32'h0);

    // Reset during the 10th MUL iteration
    present(4'd9, 32'h0000_1234, 32'h0000_0011, 32'h0, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst_n = 1'b0;
    #2;
    check("mrst_result", result, 32'h0);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    check("mrst_valid", {31'h0, out_valid}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("mrst_in_ready", {31'h0, in_ready}, 32'h1);
    present(4'd0, 32'd2, 32'd3, 32'h0, 1'b1);
    step();
    in_valid = 1'b0;
    check("mrst_add_result", result, 32'd5);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid || busy) bad++;
    end
    check("mrst_no_stale", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Parametrised execute stage for the SCC pipeline. It selects the second operand from the register file or the decoded immediate, then runs single-cycle ALU operations or an iterative multi-cycle multiply. Results are held in a registered output with N/Z/C/V flags and a valid/ready handshake on both sides. It sits between ID and the memory/writeback stage and stalls ID while a multiply is in flight or downstream is not ready.

## Interface
- WIDTH, 32: datapath width; must be ≥ 8 and a power of two.
- SHAMT_W, $clog2(WIDTH): number of low op2 bits used as the shift amount.
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ID presents an operation.
- in_ready  out  1  stage accepts the operation this cycle.
- value1  in  WIDTH  operand 1 from the register file.
- value2  in  WIDTH  operand 2 from the register file.
- immediate  in  WIDTH  immediate from ID.
- ir_op  in  1  1 = op2 is value2; 0 = op2 is immediate.
- alu_op  in  4  operation code.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream consumes the result.
- result  out  WIDTH  registered result.
- flags  out  4  {N,Z,C,V}, registered with result.
- busy  out  1  multiply in progress.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR, 7 ASR: shift value1 by op2[SHAMT_W-1:0].
  - 8 MOV: result = op2.
  - 9 MUL: low WIDTH bits of value1*op2, unsigned.
  - 10–15 reserved: result 0, flags Z=1, all other flags 0.
- Accept occurs when in_valid && in_ready, with in_ready = (state==IDLE) && (!out_valid || out_ready). Operands are captured only on accept.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - ADD: C = carry out.
  - SUB: C = no-borrow (value1 ≥ op2 unsigned).
  - V = signed overflow for ADD/SUB only.
  - C = V = 0 for all other ops.
- FSM states:
  - IDLE: non-MUL accept writes result/flags and sets out_valid on the same edge. MUL accept loads the multiplicand, multiplier and accumulator, sets count=WIDTH, and moves to MUL.
  - MUL: one shift-add per cycle with count decrementing. On the edge where count reaches 0, the stage writes result/flags, sets out_valid, and returns to IDLE. If out_ready is low at completion, the result is still written and held.
- out_valid clears on an out_ready edge unless a new accept occurs on the same edge; a same-edge accept overwrites the output register.
- result and flags are stable while out_valid && !out_ready.

## Timing
- Reset values: result=0, flags=0, out_valid=0, busy=0, state=IDLE. in_ready=1 once rst_n is high.
- Single-cycle ops: out_valid is high in the cycle after the accept edge (latency 1). A full back-to-back stream runs at 1 op/cycle with out_ready held high.
- MUL: busy is high from the accept edge until the completion edge. out_valid rises WIDTH+1 edges after the accept edge, i.e. 33 for WIDTH=32. in_ready is low throughout.
- Reset asserted mid-MUL aborts the operation with no result; all outputs return to reset values immediately (asynchronously).
- in_valid while in_ready=0 is ignored. ID must hold its operands until accept.

## Structure
- The package exe_pkg holds:
  - alu_op_t enum (4-bit codes above).
  - Flag bit indices: N=3, Z=2, C=1, V=0.
  - The state_t enum {IDLE, MUL}.
- Sub-module alu_core is purely combinational. It takes value1, op2 and alu_op and returns result plus flags for all single-cycle ops; exe_stage instantiates it once.
- The operand mux, iterative multiplier, FSM and output register are implemented in exe_stage.

## Test plan
- ADD, ir_op=0, value1=5, immediate=0xFFFFFFFB → result 0x00000000, flags Z=1 C=1 N=0 V=0; out_valid in the cycle after accept.
- SUB, ir_op=1, value1=0x80000000, value2=1 → result 0x7FFFFFFF, N=0 Z=0 C=1 V=1.
- MUL, value1=0x00010003, immediate=5 → result 0x0005000F after 33 edges; busy and !in_ready throughout; concurrent in_valid is ignored.
- Backpressure: out_ready=0, ADD 1+1 then MOV imm 7 → result holds 2 and in_ready stays low. On out_ready=1 the MOV is accepted and the next cycle shows result 7.
- ASR, value1=0x80000000, value2=0x24 → shift amount 4, result 0xF8000000, N=1.
- Reset pulse during the 10th MUL iteration → outputs zero; after release in_ready=1, and a following ADD 2+3 yields 5.
